// File: rtl/control_sequencer_if.sv
// Bundle between the hardwired control sequencer and the datapath it steers.
// The master side (the sequencer) drives every control strobe and reads IR
// and the memory handshake back; the slave side is the datapath.
// Optional build macro: SINGLE_STEP_EN adds the 'step' input.
interface control_sequencer_if #(
    parameter int IR_W = 32
);
    logic [IR_W-1:0] ir;
    logic            mem_ack;
`ifdef SINGLE_STEP_EN
    logic            step;
`endif

    logic PCout, Zlowout, Zhighout, MDRout, Cout, BAout, HIout, LOout, Rout;
    logic MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, RIn, IncPC;
    logic Gra, Grb, Grc;
    logic read, write;
    logic add, subtract, andSignal, orSignal, multiply, divide;
    logic run;
    logic [3:0] tstate;

    modport master (
`ifdef SINGLE_STEP_EN
        input  step,
`endif
        input  ir, mem_ack,
        output PCout, Zlowout, Zhighout, MDRout, Cout, BAout, HIout, LOout, Rout,
        output MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, RIn, IncPC,
        output Gra, Grb, Grc, read, write,
        output add, subtract, andSignal, orSignal, multiply, divide,
        output run, tstate
    );

    modport slave (
`ifdef SINGLE_STEP_EN
        output step,
`endif
        output ir, mem_ack,
        input  PCout, Zlowout, Zhighout, MDRout, Cout, BAout, HIout, LOout, Rout,
        input  MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, RIn, IncPC,
        input  Gra, Grb, Grc, read, write,
        input  add, subtract, andSignal, orSignal, multiply, divide,
        input  run, tstate
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer: one T-state per clock, fetch (T0-T2),
// opcode decode in T3, then the execute T-states of the instruction class.
// All strobes are registered: the output flops load the decode of the
// next state, so each strobe is glitch-free and high for its whole state.
// Optional build macro: SINGLE_STEP_EN -- instructions end in IDLE and the
// sequencer waits there for 'step' before fetching again.
module control_sequencer #(
    parameter int IR_W    = 32,
    parameter int OPC_MSB = 31
) (
    input  logic               clk,
    input  logic               clr,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        T7   = 4'd8,
        HALT = 4'd15
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_MULDIV, C_LDI, C_LD, C_ST, C_MFHI, C_MFLO, C_NOP, C_HALT
    } class_t;

    typedef struct packed {
        logic run;
        logic PCout, Zlowout, Zhighout, MDRout, Cout, BAout, HIout, LOout, Rout;
        logic MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, RIn, IncPC;
        logic Gra, Grb, Grc, read, write;
        logic add, subtract, andSignal, orSignal, multiply, divide;
    } strobe_t;

    state_t     state_q, state_d;
    logic [4:0] opc_q, opc_d;
    strobe_t    out_q;

    // Unlisted encodings fall into the nop class.
    function automatic class_t classify(input logic [4:0] opc);
        case (opc)
            5'b00000:                               return C_LD;
            5'b00001:                               return C_LDI;
            5'b00010:                               return C_ST;
            5'b00011, 5'b00100, 5'b00101, 5'b00110: return C_ALU;
            5'b01110, 5'b01111:                     return C_MULDIV;
            5'b10111:                               return C_MFHI;
            5'b11000:                               return C_MFLO;
            5'b11011:                               return C_HALT;
            default:                                return C_NOP;
        endcase
    endfunction

    // Strobe set for one state; opc only matters from T3 on.
    function automatic strobe_t decodeOut(input state_t s, input logic [4:0] opc);
        strobe_t o;
        class_t  cls;
        o   = '0;
        cls = classify(opc);
        o.run = (s != IDLE) && (s != HALT);
        case (s)
            T0: begin o.PCout = 1'b1; o.MARIn = 1'b1; o.IncPC = 1'b1; o.ZIn = 1'b1; end
            T1: begin o.Zlowout = 1'b1; o.PCIn = 1'b1; o.read = 1'b1; o.MDRIn = 1'b1; end
            T2: begin o.MDRout = 1'b1; o.IRIn = 1'b1; end
            T3: begin
                case (cls)
                    C_ALU:              begin o.Grb = 1'b1; o.Rout = 1'b1; o.YIn = 1'b1; end
                    C_MULDIV:           begin o.Gra = 1'b1; o.Rout = 1'b1; o.YIn = 1'b1; end
                    C_LDI, C_LD, C_ST:  begin o.Grb = 1'b1; o.BAout = 1'b1; o.YIn = 1'b1; end
                    C_MFHI:             begin o.HIout = 1'b1; o.Gra = 1'b1; o.RIn = 1'b1; end
                    C_MFLO:             begin o.LOout = 1'b1; o.Gra = 1'b1; o.RIn = 1'b1; end
                    default:            ;
                endcase
            end
            T4: begin
                o.ZIn = 1'b1;
                case (cls)
                    C_ALU: begin
                        o.Grc  = 1'b1;
                        o.Rout = 1'b1;
                        case (opc)
                            5'b00011: o.add       = 1'b1;
                            5'b00100: o.subtract  = 1'b1;
                            5'b00101: o.andSignal = 1'b1;
                            default:  o.orSignal  = 1'b1;
                        endcase
                    end
                    C_MULDIV: begin
                        o.Grb  = 1'b1;
                        o.Rout = 1'b1;
                        if (opc == 5'b01110) o.multiply = 1'b1;
                        else                 o.divide   = 1'b1;
                    end
                    default: begin o.Cout = 1'b1; o.add = 1'b1; end
                endcase
            end
            T5: begin
                o.Zlowout = 1'b1;
                case (cls)
                    C_MULDIV:    o.LoIn  = 1'b1;
                    C_LD, C_ST:  o.MARIn = 1'b1;
                    default:     begin o.Gra = 1'b1; o.RIn = 1'b1; end
                endcase
            end
            T6: begin
                case (cls)
                    C_MULDIV: begin o.Zhighout = 1'b1; o.HiIn = 1'b1; end
                    C_LD:     begin o.read = 1'b1; o.MDRIn = 1'b1; end
                    default:  begin o.Gra = 1'b1; o.Rout = 1'b1; o.MDRIn = 1'b1; end
                endcase
            end
            T7: begin
                if (cls == C_LD) begin
                    o.MDRout = 1'b1; o.Gra = 1'b1; o.RIn = 1'b1;
                end else begin
                    o.write = 1'b1;
                end
            end
            default: ;
        endcase
        return o;
    endfunction

    // Next T-state and opcode latch; the opcode is captured on the edge leaving T2.
    always_comb begin
        state_t doneState;
        class_t cls;
`ifdef SINGLE_STEP_EN
        doneState = IDLE;
`else
        doneState = T0;
`endif
        cls     = classify(opc_q);
        state_d = state_q;
        opc_d   = opc_q;
        case (state_q)
            IDLE: begin
`ifdef SINGLE_STEP_EN
                if (bus.step) state_d = T0;
`else
                state_d = T0;
`endif
            end
            T0: state_d = T1;
            T1: if (bus.mem_ack) state_d = T2;
            T2: begin
                state_d = T3;
                opc_d   = bus.ir[OPC_MSB -: 5];
            end
            T3: begin
                case (cls)
                    C_ALU, C_MULDIV, C_LDI, C_LD, C_ST: state_d = T4;
                    C_HALT:                             state_d = HALT;
                    default:                            state_d = doneState;
                endcase
            end
            T4: state_d = T5;
            T5: state_d = (cls == C_ALU || cls == C_LDI) ? doneState : T6;
            T6: begin
                case (cls)
                    C_LD:    if (bus.mem_ack) state_d = T7;
                    C_ST:    state_d = T7;
                    default: state_d = doneState;
                endcase
            end
            T7: begin
                if (cls == C_LD || bus.mem_ack) state_d = doneState;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // State, opcode and registered strobes; clr aborts to IDLE with everything low.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            opc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            out_q   <= decodeOut(state_d, opc_d);
        end
    end

    assign bus.run       = out_q.run;
    assign bus.PCout     = out_q.PCout;
    assign bus.Zlowout   = out_q.Zlowout;
    assign bus.Zhighout  = out_q.Zhighout;
    assign bus.MDRout    = out_q.MDRout;
    assign bus.Cout      = out_q.Cout;
    assign bus.BAout     = out_q.BAout;
    assign bus.HIout     = out_q.HIout;
    assign bus.LOout     = out_q.LOout;
    assign bus.Rout      = out_q.Rout;
    assign bus.MARIn     = out_q.MARIn;
    assign bus.PCIn      = out_q.PCIn;
    assign bus.MDRIn     = out_q.MDRIn;
    assign bus.IRIn      = out_q.IRIn;
    assign bus.YIn       = out_q.YIn;
    assign bus.ZIn       = out_q.ZIn;
    assign bus.HiIn      = out_q.HiIn;
    assign bus.LoIn      = out_q.LoIn;
    assign bus.RIn       = out_q.RIn;
    assign bus.IncPC     = out_q.IncPC;
    assign bus.Gra       = out_q.Gra;
    assign bus.Grb       = out_q.Grb;
    assign bus.Grc       = out_q.Grc;
    assign bus.read      = out_q.read;
    assign bus.write     = out_q.write;
    assign bus.add       = out_q.add;
    assign bus.subtract  = out_q.subtract;
    assign bus.andSignal = out_q.andSignal;
    assign bus.orSignal  = out_q.orSignal;
    assign bus.multiply  = out_q.multiply;
    assign bus.divide    = out_q.divide;
    assign bus.tstate    = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer (default build, SINGLE_STEP_EN
// undefined). Each instruction is described as a list of expected T-states
// and strobe sets; the DUT is stepped through it with optional memory waits.
module tb_control_sequencer;

    logic clk = 1'b0;
    logic clr;

    control_sequencer_if #(.IR_W(32)) bus ();

    control_sequencer #(.IR_W(32), .OPC_MSB(31)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Observed strobes, bit 30 = run down to bit 0 = divide.
    logic [30:0] obs;
    assign obs = {bus.run,
                  bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.Cout,
                  bus.BAout, bus.HIout, bus.LOout, bus.Rout,
                  bus.MARIn, bus.PCIn, bus.MDRIn, bus.IRIn, bus.YIn, bus.ZIn,
                  bus.HiIn, bus.LoIn, bus.RIn, bus.IncPC,
                  bus.Gra, bus.Grb, bus.Grc, bus.read, bus.write,
                  bus.add, bus.subtract, bus.andSignal, bus.orSignal,
                  bus.multiply, bus.divide};

    localparam logic [30:0] ONE  = 31'd1;
    localparam logic [30:0] RUN  = ONE << 30;
    localparam logic [30:0] PCO  = ONE << 29;
    localparam logic [30:0] ZLO  = ONE << 28;
    localparam logic [30:0] ZHI  = ONE << 27;
    localparam logic [30:0] MDRO = ONE << 26;
    localparam logic [30:0] CO   = ONE << 25;
    localparam logic [30:0] BAO  = ONE << 24;
    localparam logic [30:0] HIO  = ONE << 23;
    localparam logic [30:0] LOO  = ONE << 22;
    localparam logic [30:0] RO   = ONE << 21;
    localparam logic [30:0] MARI = ONE << 20;
    localparam logic [30:0] PCI  = ONE << 19;
    localparam logic [30:0] MDRI = ONE << 18;
    localparam logic [30:0] IRI  = ONE << 17;
    localparam logic [30:0] YI   = ONE << 16;
    localparam logic [30:0] ZI   = ONE << 15;
    localparam logic [30:0] HII  = ONE << 14;
    localparam logic [30:0] LOI  = ONE << 13;
    localparam logic [30:0] RI   = ONE << 12;
    localparam logic [30:0] INC  = ONE << 11;
    localparam logic [30:0] GRA  = ONE << 10;
    localparam logic [30:0] GRB  = ONE << 9;
    localparam logic [30:0] GRC  = ONE << 8;
    localparam logic [30:0] RD   = ONE << 7;
    localparam logic [30:0] WR   = ONE << 6;
    localparam logic [30:0] ADD  = ONE << 5;
    localparam logic [30:0] SUB  = ONE << 4;
    localparam logic [30:0] ANDS = ONE << 3;
    localparam logic [30:0] ORS  = ONE << 2;
    localparam logic [30:0] MUL  = ONE << 1;
    localparam logic [30:0] DIV  = ONE << 0;
    localparam logic [30:0] ALU_MASK = ADD | SUB | ANDS | ORS | MUL | DIV;

    typedef struct {
        logic [3:0]  ts;
        logic [30:0] mask;
        bit          waits;
    } step_t;

    typedef struct {
        logic [4:0]  opc;
        int          ackWait;
        int          expRunCycles;
        logic [30:0] expAlu;
    } vec_t;

    step_t prog[$];
    int    checks = 0;
    int    failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expTs,
                               input logic [30:0] expMask);
        checks++;
        if (bus.tstate !== expTs || obs !== expMask) begin
            failures++;
            $display("[TB] FAIL %s: got tstate=%0d strobes=%h, expected tstate=%0d strobes=%h",
                     name, bus.tstate, obs, expTs, expMask);
        end
        checks++;
        if ($countones(obs[29:21]) > 1) begin
            failures++;
            $display("[TB] FAIL %s bus drivers: got %h, expected at most one", name, obs[29:21]);
        end
    endtask

    task automatic pushStep(input logic [30:0] mask, input bit waits);
        step_t s;
        s.ts    = 4'(prog.size() + 1);
        s.mask  = mask | RUN;
        s.waits = waits;
        prog.push_back(s);
    endtask

    // Reference micro-program of one instruction, from T0 to its last T-state.
    task automatic buildProgram(input logic [4:0] opc);
        prog.delete();
        pushStep(PCO | MARI | INC | ZI, 1'b0);
        pushStep(ZLO | PCI | RD | MDRI, 1'b1);
        pushStep(MDRO | IRI, 1'b0);
        case (opc)
            5'd3, 5'd4, 5'd5, 5'd6: begin
                pushStep(GRB | RO | YI, 1'b0);
                pushStep(GRC | RO | ZI | ((opc == 5'd3) ? ADD : (opc == 5'd4) ? SUB :
                                          (opc == 5'd5) ? ANDS : ORS), 1'b0);
                pushStep(ZLO | GRA | RI, 1'b0);
            end
            5'd14, 5'd15: begin
                pushStep(GRA | RO | YI, 1'b0);
                pushStep(GRB | RO | ZI | ((opc == 5'd14) ? MUL : DIV), 1'b0);
                pushStep(ZLO | LOI, 1'b0);
                pushStep(ZHI | HII, 1'b0);
            end
            5'd0, 5'd1, 5'd2: begin
                pushStep(GRB | BAO | YI, 1'b0);
                pushStep(CO | ADD | ZI, 1'b0);
                if (opc == 5'd1) begin
                    pushStep(ZLO | GRA | RI, 1'b0);
                end else if (opc == 5'd0) begin
                    pushStep(ZLO | MARI, 1'b0);
                    pushStep(RD | MDRI, 1'b1);
                    pushStep(MDRO | GRA | RI, 1'b0);
                end else begin
                    pushStep(ZLO | MARI, 1'b0);
                    pushStep(GRA | RO | MDRI, 1'b0);
                    pushStep(WR, 1'b1);
                end
            end
            5'd23:   pushStep(HIO | GRA | RI, 1'b0);
            5'd24:   pushStep(LOO | GRA | RI, 1'b0);
            default: pushStep('0, 1'b0);
        endcase
    endtask

    // Runs one instruction starting at T0; every memory wait is stretched ackWait cycles.
    task automatic applyStimulus(input logic [4:0] opc, input int ackWait,
                                 output int runCycles, output logic [30:0] aluSeen);
        string name;
        bus.ir      = {opc, 27'($urandom)};
        bus.mem_ack = 1'b1;
        buildProgram(opc);
        runCycles = 0;
        aluSeen   = '0;
        foreach (prog[i]) begin
            name = $sformatf("opc%0d T%0d", opc, prog[i].ts - 4'd1);
            checkOutput(name, prog[i].ts, prog[i].mask);
            runCycles += int'(bus.run);
            aluSeen   |= obs & ALU_MASK;
            if (prog[i].waits) begin
                for (int k = 0; k < ackWait; k++) begin
                    bus.mem_ack = 1'b0;
                    tick();
                    checkOutput({name, " wait"}, prog[i].ts, prog[i].mask);
                    runCycles += int'(bus.run);
                    aluSeen   |= obs & ALU_MASK;
                end
                bus.mem_ack = 1'b1;
            end
            tick();
        end
    endtask

    vec_t        vecs[14];
    int          runCycles;
    logic [30:0] aluSeen;
    logic [4:0]  ropc;

    initial begin
        vecs[0]  = '{5'b00011, 0, 6,  ADD};
        vecs[1]  = '{5'b00100, 1, 7,  SUB};
        vecs[2]  = '{5'b00101, 0, 6,  ANDS};
        vecs[3]  = '{5'b00110, 2, 8,  ORS};
        vecs[4]  = '{5'b01110, 0, 7,  MUL};
        vecs[5]  = '{5'b01111, 2, 9,  DIV};
        vecs[6]  = '{5'b00001, 0, 6,  ADD};
        vecs[7]  = '{5'b00000, 1, 10, ADD};
        vecs[8]  = '{5'b00010, 4, 16, ADD};
        vecs[9]  = '{5'b10111, 0, 4,  '0};
        vecs[10] = '{5'b11000, 0, 4,  '0};
        vecs[11] = '{5'b11010, 0, 4,  '0};
        vecs[12] = '{5'b11111, 0, 4,  '0};
        vecs[13] = '{5'b10000, 3, 7,  '0};

        clr         = 1'b1;
        bus.ir      = '0;
        bus.mem_ack = 1'b1;
`ifdef SINGLE_STEP_EN
        bus.step    = 1'b1;
`endif
        tick();
        tick();
        checkOutput("reset idle", 4'd0, '0);
        clr = 1'b0;
        tick();

        for (int v = 0; v < 14; v++) begin
            applyStimulus(vecs[v].opc, vecs[v].ackWait, runCycles, aluSeen);
            checks++;
            if (runCycles != vecs[v].expRunCycles) begin
                failures++;
                $display("[TB] FAIL vec%0d run cycles: got %0d, expected %0d",
                         v, runCycles, vecs[v].expRunCycles);
            end
            checks++;
            if (aluSeen !== vecs[v].expAlu) begin
                failures++;
                $display("[TB] FAIL vec%0d alu ops: got %h, expected %h",
                         v, aluSeen, vecs[v].expAlu);
            end
        end

        // halt parks the sequencer until clr
        applyStimulus(5'b11011, 0, runCycles, aluSeen);
        for (int c = 0; c < 20; c++) begin
            checkOutput("halt", 4'd15, '0);
            tick();
        end
        clr = 1'b1;
        tick();
        checkOutput("halt clr", 4'd0, '0);
        clr = 1'b0;
        tick();

        // reset while an ld is stalled in T6
        bus.ir      = 32'h0000_1234;
        bus.mem_ack = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        bus.mem_ack = 1'b0;
        checkOutput("ld T6 stall", 4'd7, RUN | RD | MDRI);
        clr = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("mid reset", 4'd0, '0);
        end
        clr         = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        checkOutput("restart T0", 4'd1, RUN | PCO | MARI | INC | ZI);
        tick();
        checkOutput("restart T1", 4'd2, RUN | ZLO | PCI | RD | MDRI);
        tick();
        checkOutput("restart T2", 4'd3, RUN | MDRO | IRI);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();

        // random instruction stream against the reference micro-programs
        for (int r = 0; r < 40; r++) begin
            ropc = 5'($urandom_range(0, 31));
            while (ropc == 5'b11011) ropc = 5'($urandom_range(0, 31));
            applyStimulus(ropc, int'($urandom_range(0, 3)), runCycles, aluSeen);
        end
        checkOutput("final T0", 4'd1, RUN | PCO | MARI | INC | ZI);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
